// File: rtl/uart_tx_frame_pkg.sv
// Shared UART definitions: parity mode encodings, frame FSM state encoding and the
// half-bit period helper. The matching RX block reuses the same definitions.
package uart_tx_frame_pkg;

    localparam int unsigned ParityNone = 0;
    localparam int unsigned ParityEven = 1;
    localparam int unsigned ParityOdd  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    // Clock cycles per half bit, truncated.
    function automatic int unsigned half_bit_cycles(input int unsigned clk_hz,
                                                    input int unsigned baud);
        return clk_hz / (2 * baud);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Restartable half-bit tick generator.
// Ports:
//   clock   - system clock
//   reset   - asynchronous active-high reset
//   restart - zero the counter on the next edge (overrides counting)
//   tick    - high in the last cycle of every HalfBit-cycle period
module uart_baud_tick #(
    parameter int unsigned HalfBit = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CntW = (HalfBit > 1) ? $clog2(HalfBit) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(HalfBit - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, DataBits data bits LSB first, optional parity and a
// 1 / 1.5 / 2 bit stop period, launched by a single start request.
// Ports:
//   clock             - system clock, all state on rising edge
//   reset             - asynchronous active-high reset
//   startTransmission - frame request, accepted in IDLE or in the done cycle
//   data              - payload, latched on acceptance
//   busy              - high while a frame is on the line
//   done              - one-cycle pulse in the final cycle of the stop period
//   tx                - serial line, idle high
module uart_tx_frame
    import uart_tx_frame_pkg::*;
#(
    parameter int unsigned ClockFrequency = 1000000,
    parameter int unsigned BaudRate       = 9600,
    parameter int unsigned DataBits       = 8,
    parameter int unsigned ParityMode     = 0,
    parameter int unsigned StopHalfBits   = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                startTransmission,
    input  logic [DataBits-1:0] data,
    output logic                busy,
    output logic                done,
    output logic                tx
);

    localparam int unsigned HalfBit = half_bit_cycles(ClockFrequency, BaudRate);
    localparam logic [1:0]  LastStopHalf = 2'(StopHalfBits - 1);
    localparam logic [3:0]  LastBit = 4'(DataBits - 1);
    localparam bit          HasParity = (ParityMode != ParityNone);

    if (DataBits < 5 || DataBits > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DataBits must be 5..9");
    end
    if (ParityMode > ParityOdd) begin : g_bad_parity
        $error("uart_tx_frame: ParityMode must be 0, 1 or 2");
    end
    if (StopHalfBits < 2 || StopHalfBits > 4) begin : g_bad_stop
        $error("uart_tx_frame: StopHalfBits must be 2, 3 or 4");
    end
    if (HalfBit < 1) begin : g_bad_rate
        $error("uart_tx_frame: ClockFrequency too low for BaudRate");
    end

    tx_state_e           state_q, state_d;
    logic [1:0]          half_q, half_d;    // half bits elapsed in the current field
    logic [3:0]          bit_q, bit_d;      // data bit index
    logic [DataBits-1:0] data_q, data_d;    // latched payload, shifted right per bit
    logic                par_q, par_d;      // parity computed once at acceptance

    logic tick;
    logic restart;
    logic frame_done;
    logic accept;

    uart_baud_tick #(
        .HalfBit(HalfBit)
    ) u_baud_tick (
        .clock  (clock),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

    assign frame_done = (state_q == StStop) && tick && (half_q == LastStopHalf);
    assign accept     = startTransmission && ((state_q == StIdle) || frame_done);

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        bit_d   = bit_q;
        data_d  = data_q;
        par_d   = par_q;

        // Shared load action for IDLE and back-to-back acceptance.
        if (accept) begin
            state_d = StStart;
            half_d  = '0;
            bit_d   = '0;
            data_d  = data;
            par_d   = (ParityMode == ParityOdd) ? ~^data : ^data;
        end

        unique case (state_q)
            StIdle: ;
            StStart: begin
                if (tick) begin
                    if (half_q[0]) begin
                        state_d = StData;
                        half_d  = '0;
                        bit_d   = '0;
                    end else begin
                        half_d = 2'd1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    if (half_q[0]) begin
                        half_d = '0;
                        data_d = data_q >> 1;
                        if (bit_q == LastBit) begin
                            state_d = HasParity ? StParity : StStop;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end else begin
                        half_d = 2'd1;
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    if (half_q[0]) begin
                        state_d = StStop;
                        half_d  = '0;
                    end else begin
                        half_d = 2'd1;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    if (half_q == LastStopHalf) begin
                        if (!accept) begin
                            state_d = StIdle;
                            half_d  = '0;
                        end
                    end else begin
                        half_d = half_q + 2'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Timer is held at zero in IDLE and realigned on every field change.
    assign restart = (state_d != state_q) || (state_q == StIdle);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            half_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            par_q   <= par_d;
        end
    end

    // Outputs decode registered state only, so inputs never reach them combinationally.
    always_comb begin
        busy = (state_q != StIdle);
        done = frame_done;
        tx   = 1'b1;
        unique case (state_q)
            StStart:  tx = 1'b0;
            StData:   tx = data_q[0];
            StParity: tx = par_q;
            default:  tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame with H=4 (8-cycle bits). Six instances cover 8N1, even/odd
// parity, 1.5 and 2 stop bits and 5 data bits. Expected {tx,busy,done} per cycle is
// queued by a frame model when a request is issued and popped as the DUT runs.
module tb_uart_tx_frame;

    localparam int Hb = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_r [6];
    logic [7:0] data8   [5];
    logic [4:0] data5;
    logic       tx_w    [6];
    logic       busy_w  [6];
    logic       done_w  [6];

    int checks = 0;
    int passed = 0;
    logic [2:0] exp_q[$];

    always #5 clock = ~clock;

    uart_tx_frame #(.ClockFrequency(800), .BaudRate(100), .DataBits(8),
                    .ParityMode(0), .StopHalfBits(2)) u_dut_8n1 (
        .clock(clock), .reset(reset), .startTransmission(start_r[0]), .data(data8[0]),
        .busy(busy_w[0]), .done(done_w[0]), .tx(tx_w[0]));
    uart_tx_frame #(.ClockFrequency(800), .BaudRate(100), .DataBits(8),
                    .ParityMode(1), .StopHalfBits(2)) u_dut_even (
        .clock(clock), .reset(reset), .startTransmission(start_r[1]), .data(data8[1]),
        .busy(busy_w[1]), .done(done_w[1]), .tx(tx_w[1]));
    uart_tx_frame #(.ClockFrequency(800), .BaudRate(100), .DataBits(8),
                    .ParityMode(2), .StopHalfBits(2)) u_dut_odd (
        .clock(clock), .reset(reset), .startTransmission(start_r[2]), .data(data8[2]),
        .busy(busy_w[2]), .done(done_w[2]), .tx(tx_w[2]));
    uart_tx_frame #(.ClockFrequency(800), .BaudRate(100), .DataBits(8),
                    .ParityMode(0), .StopHalfBits(3)) u_dut_stop15 (
        .clock(clock), .reset(reset), .startTransmission(start_r[3]), .data(data8[3]),
        .busy(busy_w[3]), .done(done_w[3]), .tx(tx_w[3]));
    uart_tx_frame #(.ClockFrequency(800), .BaudRate(100), .DataBits(8),
                    .ParityMode(0), .StopHalfBits(4)) u_dut_stop2 (
        .clock(clock), .reset(reset), .startTransmission(start_r[4]), .data(data8[4]),
        .busy(busy_w[4]), .done(done_w[4]), .tx(tx_w[4]));
    uart_tx_frame #(.ClockFrequency(800), .BaudRate(100), .DataBits(5),
                    .ParityMode(0), .StopHalfBits(2)) u_dut_5bit (
        .clock(clock), .reset(reset), .startTransmission(start_r[5]), .data(data5),
        .busy(busy_w[5]), .done(done_w[5]), .tx(tx_w[5]));

    function automatic logic [2:0] obs(input int i);
        return {tx_w[i], busy_w[i], done_w[i]};
    endfunction

    // Frame model: pushes one {tx,busy,done} entry per clock cycle of the frame.
    task automatic model_frame(input logic [8:0] d, input int nbits, input int pmode,
                               input int shb);
        logic p;
        p = 1'b0;
        for (int i = 0; i < nbits; i++) p = p ^ d[i];
        if (pmode == 2) p = ~p;
        repeat (2 * Hb) exp_q.push_back(3'b010);
        for (int i = 0; i < nbits; i++) begin
            repeat (2 * Hb) exp_q.push_back({d[i], 2'b10});
        end
        if (pmode != 0) begin
            repeat (2 * Hb) exp_q.push_back({p, 2'b10});
        end
        for (int i = 0; i < shb * Hb; i++) begin
            exp_q.push_back((i == shb * Hb - 1) ? 3'b111 : 3'b110);
        end
    endtask

    // One-cycle request; returns at the negedge after the accepting edge (cycle 1).
    task automatic launch(input int i, input logic [8:0] d);
        @(negedge clock);
        start_r[i] = 1'b1;
        if (i == 5) data5 = d[4:0];
        else data8[i] = d[7:0];
        @(negedge clock);
        start_r[i] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        data5 = '0;
        for (int i = 0; i < 6; i++) start_r[i] = 1'b0;
        for (int i = 0; i < 5; i++) data8[i] = '0;
        @(negedge clock);
        @(negedge clock);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs(i) !== 3'b100)
                $display("FAIL reset dut%0d: {tx,busy,done}=%b expected 100", i, obs(i));
            else passed++;
        end
        reset = 1'b0;
    endtask

    task automatic test_8n1();
        int c;
        logic [2:0] e, g;
        model_frame(9'h055, 8, 0, 2);
        launch(0, 9'h055);
        c = 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = obs(0);
            checks++;
            if (g !== e) $display("FAIL 8n1 cycle %0d: got %b expected %b", c, g, e);
            else passed++;
            c++;
            @(negedge clock);
        end
        checks++;
        if (obs(0) !== 3'b100) $display("FAIL 8n1 idle: got %b expected 100", obs(0));
        else passed++;
    endtask

    task automatic test_parity();
        int c;
        logic [2:0] e, g;
        for (int k = 1; k <= 2; k++) begin
            model_frame(9'h007, 8, k, 2);
            if (exp_q.size() != 88) $display("FAIL parity model length %0d expected 88",
                                             exp_q.size());
            launch(k, 9'h007);
            c = 1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = obs(k);
                checks++;
                if (g !== e)
                    $display("FAIL parity mode%0d cycle %0d: got %b expected %b", k, c, g, e);
                else passed++;
                c++;
                @(negedge clock);
            end
            checks++;
            if (obs(k) !== 3'b100)
                $display("FAIL parity mode%0d idle: got %b expected 100", k, obs(k));
            else passed++;
        end
    endtask

    task automatic test_stop_bits();
        int c;
        logic [2:0] e, g;
        for (int k = 3; k <= 4; k++) begin
            model_frame(9'h0A5, 8, 0, k);
            launch(k, 9'h0A5);
            c = 1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = obs(k);
                checks++;
                if (g !== e)
                    $display("FAIL stop%0dhalf cycle %0d: got %b expected %b", k, c, g, e);
                else passed++;
                c++;
                @(negedge clock);
            end
            checks++;
            if (obs(k) !== 3'b100)
                $display("FAIL stop%0dhalf idle: got %b expected 100", k, obs(k));
            else passed++;
        end
    endtask

    task automatic test_five_bits();
        int c;
        logic [2:0] e, g;
        model_frame(9'h01F, 5, 0, 2);
        launch(5, 9'h01F);
        c = 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = obs(5);
            checks++;
            if (g !== e) $display("FAIL five_bits cycle %0d: got %b expected %b", c, g, e);
            else passed++;
            c++;
            @(negedge clock);
        end
        checks++;
        if (obs(5) !== 3'b100) $display("FAIL five_bits idle: got %b expected 100", obs(5));
        else passed++;
    endtask

    task automatic test_back_to_back();
        int c, n_done, first_done, second_done;
        logic [2:0] e, g;
        n_done = 0;
        first_done = 0;
        second_done = 0;
        model_frame(9'h0A0, 8, 0, 2);
        model_frame(9'h00F, 8, 0, 2);
        @(negedge clock);
        start_r[0] = 1'b1;
        data8[0] = 8'hA0;
        @(negedge clock);
        data8[0] = 8'h0F;
        c = 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = obs(0);
            checks++;
            if (g !== e) $display("FAIL back_to_back cycle %0d: got %b expected %b", c, g, e);
            else passed++;
            if (done_w[0] === 1'b1) begin
                n_done++;
                if (n_done == 1) first_done = c;
                else second_done = c;
            end
            if (c == 100) start_r[0] = 1'b0;
            c++;
            @(negedge clock);
        end
        checks++;
        if (n_done != 2 || second_done - first_done != 80)
            $display("FAIL back_to_back done pulses: count %0d gap %0d expected 2 and 80",
                     n_done, second_done - first_done);
        else passed++;
        checks++;
        if (obs(0) !== 3'b100) $display("FAIL back_to_back idle: got %b expected 100", obs(0));
        else passed++;
    endtask

    task automatic test_ignore_busy();
        int c;
        logic [2:0] e, g;
        model_frame(9'h05A, 8, 0, 2);
        launch(0, 9'h05A);
        c = 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = obs(0);
            checks++;
            if (g !== e) $display("FAIL ignore_busy cycle %0d: got %b expected %b", c, g, e);
            else passed++;
            if (c == 20) begin
                start_r[0] = 1'b1;
                data8[0] = 8'hFF;
            end
            if (c == 26) start_r[0] = 1'b0;
            c++;
            @(negedge clock);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs(0) !== 3'b100)
                $display("FAIL ignore_busy idle+%0d: got %b expected 100", i, obs(0));
            else passed++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        logic [2:0] e, g;
        model_frame(9'h096, 8, 0, 2);
        launch(0, 9'h096);
        c = 1;
        while (c <= 36) begin
            e = exp_q.pop_front();
            g = obs(0);
            checks++;
            if (g !== e) $display("FAIL reset_mid pre cycle %0d: got %b expected %b", c, g, e);
            else passed++;
            c++;
            @(negedge clock);
        end
        exp_q.delete();
        reset = 1'b1;
        #1;
        checks++;
        if (obs(0) !== 3'b100)
            $display("FAIL reset_mid async: got %b expected 100", obs(0));
        else passed++;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_frame(9'h0C3, 8, 0, 2);
        launch(0, 9'h0C3);
        c = 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = obs(0);
            checks++;
            if (g !== e) $display("FAIL reset_mid post cycle %0d: got %b expected %b", c, g, e);
            else passed++;
            c++;
            @(negedge clock);
        end
        checks++;
        if (obs(0) !== 3'b100) $display("FAIL reset_mid idle: got %b expected 100", obs(0));
        else passed++;
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_stop_bits();
        test_five_bits();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
